ifetch_bp_queue: RTL
====================

Name: ifetch_bp_queue

Overview:
- Parametrised next-generation fetch unit. Sequences the PC and issues requests to the icache.
- Predicts conditional branches with an indexed table of 2-bit saturating counters. Resolves JAL targets locally and stalls on JALR.
- Buffers fetched instructions in an IQ_DEPTH-entry queue that decouples the icache from the decode/issue stage.
- Sits between the icache and the decoder/issue logic; the ROB drives redirects and predictor training.

Parameters:
- BHT_BITS, 7: log2 of the predictor entry count; index = pc[BHT_BITS+1:2].
- IQ_DEPTH_LOG, 3: log2 of the instruction queue depth (depth 8).
- RESET_PC, 32'h0: PC loaded at reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when low, all state freezes
- ic_addr  out  32  fetch address, equal to the current pc
- ic_addr_valid  out  1  fetch request
- ic_ins_valid  in  1  one-cycle pulse; instruction for ic_addr is valid
- ic_ins  in  32  fetched instruction
- ic_pc_change  out  1  one-cycle pulse: pc moved non-sequentially, icache drops its outstanding request
- iq_valid  out  1  queue head valid
- iq_ready  in  1  issue stage accepts the head (already deasserted by issue when ROB/LSB full)
- iq_inst  out  32  head instruction
- iq_pc  out  32  head PC
- iq_pred_taken  out  1  head prediction
- iq_pred_pc  out  32  predicted next PC of head
- redirect_valid  in  1  ROB mispredict/rollback
- redirect_pc  in  32  correct PC
- jalr_valid  in  1  JALR target resolved
- jalr_target  in  32  JALR target
- bht_upd_valid  in  1  train predictor
- bht_upd_pc  in  32  PC of the resolved branch
- bht_upd_taken  in  1  actual branch outcome

Behaviour:
Reset:
- pc=RESET_PC; queue empty; wait_jalr=0; ic_pc_change=0.
- Every predictor counter = 2'b01 (weakly not taken).
- Outputs: iq_valid=0, ic_addr_valid=0 on the cycle after reset, iq_* = 0.
- Reset mid-operation discards everything, including a response arriving in the reset cycle.

rdy=0:
- No pc change, push, pop, or predictor update.
- ic_addr_valid=0 combinationally.

Request generation:
- ic_addr_valid = rdy && !rst && !wait_jalr && !full.
- ic_addr = pc, held stable until ic_ins_valid or a redirect.

On ic_ins_valid (accepted only when ic_addr_valid=1 and no redirect this cycle):
- Push {ic_ins, pc, pred_taken, pred_pc}.
- Next pc, decoded from opcode ic_ins[6:0]:
  - JAL (1101111): pc + J-imm, pred_taken=1.
  - BRANCH (1100011): if counter[idx] >= 2'b10 then pc + B-imm and pred_taken=1; else pc+4.
  - JALR (1100111): pc+4 recorded as pred_pc, pred_taken=0; set wait_jalr.
  - Other: pc+4.
- J-imm and B-imm are sign-extended to 32 bits; the PC add wraps modulo 2^32.
- ic_pc_change=1 next cycle when the new pc ≠ old pc+4.

jalr_valid while wait_jalr:
- pc=jalr_target; wait_jalr=0; ic_pc_change pulses.
- jalr_valid while not waiting is ignored.

redirect_valid (highest priority after rst):
- Queue flushed; pc=redirect_pc; wait_jalr=0; ic_pc_change pulses.
- A same-cycle ic_ins_valid is dropped; a same-cycle pop has no effect (all entries cleared).

Predictor update:
- bht_upd_valid: counter[bht_upd_pc[BHT_BITS+1:2]] saturating +1 if taken, -1 if not (00 and 11 hold).
- Updates are independent of redirect and apply in the same cycle.
- A lookup of the same index in the same cycle sees the pre-update value.

Queue:
- Circular buffer with IQ_DEPTH_LOG-bit pointers that wrap and a count of IQ_DEPTH_LOG+1 bits.
- full = (count == 2^IQ_DEPTH_LOG); iq_valid = (count != 0).
- Pop when iq_valid && iq_ready.
- Simultaneous push and pop leaves count unchanged and is legal when full (no request is raised when full, so a push cannot arrive then).
- iq_* reflect the head combinationally from registered storage.

Test Plan:
- Reset, then 4 sequential non-branch responses from 0x0 with iq_ready=1 -> ic_addr 0,4,8,C; iq_pc 0,4,8,C in order; ic_pc_change stays 0.
- BEQ at 0x10 with B-imm=+0x20 and counter 01 -> next ic_addr=0x14, pred_taken=0. Send bht_upd taken ×2 for pc 0x10, re-fetch 0x10 -> next ic_addr=0x30, pred_taken=1; counter saturates at 11 after a third taken update.
- iq_ready=0, 8 responses -> count=8, ic_addr_valid=0. Raise iq_ready for one cycle -> one pop, then a request reissues. Check pointer wrap after 20 total push/pop.
- JALR at 0x40 -> ic_addr_valid low. jalr_valid with target 0x100 -> ic_addr=0x100, one ic_pc_change pulse.
- Queue holding 5 entries, redirect_valid with redirect_pc=0x200 in the same cycle as ic_ins_valid and a pop -> next cycle iq_valid=0, ic_addr=0x200, the response is discarded, wait_jalr cleared.
- rdy=0 for 3 cycles with responses and redirects asserted -> pc, count, and counters unchanged.

Source files
------------

// File: rtl/ifetch_bp_queue.sv
// Fetch unit: PC sequencing, 2-bit counter branch prediction, JAL/JALR handling
// and an instruction queue between the icache and the issue stage.
module ifetch_bp_queue #(
    parameter int          BHT_BITS     = 7,
    parameter int          IQ_DEPTH_LOG = 3,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic [31:0] ic_addr,
    output logic        ic_addr_valid,
    input  logic        ic_ins_valid,
    input  logic [31:0] ic_ins,
    output logic        ic_pc_change,
    output logic        iq_valid,
    input  logic        iq_ready,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc,
    output logic        iq_pred_taken,
    output logic [31:0] iq_pred_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        jalr_valid,
    input  logic [31:0] jalr_target,
    input  logic        bht_upd_valid,
    input  logic [31:0] bht_upd_pc,
    input  logic        bht_upd_taken
);
    localparam int BHT_SIZE = 1 << BHT_BITS;
    localparam int IQ_DEPTH = 1 << IQ_DEPTH_LOG;
    localparam logic [IQ_DEPTH_LOG-1:0] PTR_ONE  = IQ_DEPTH_LOG'(1);
    localparam logic [IQ_DEPTH_LOG:0]   CNT_ONE  = (IQ_DEPTH_LOG+1)'(1);
    localparam logic [IQ_DEPTH_LOG:0]   CNT_FULL = (IQ_DEPTH_LOG+1)'(IQ_DEPTH);
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    function automatic logic [31:0] j_imm(input logic [31:0] ins);
        return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] b_imm(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == 2'b11) ? cnt : cnt + 2'b01;
        end else begin
            res = (cnt == 2'b00) ? cnt : cnt - 2'b01;
        end
        return res;
    endfunction

    logic [31:0]             r_pc;
    logic                    r_wait_jalr;
    logic                    r_pc_change;
    logic [1:0]              r_bht [BHT_SIZE];
    logic [31:0]             r_q_inst    [IQ_DEPTH];
    logic [31:0]             r_q_pc      [IQ_DEPTH];
    logic [31:0]             r_q_pred_pc [IQ_DEPTH];
    logic                    r_q_taken   [IQ_DEPTH];
    logic [IQ_DEPTH_LOG-1:0] r_head;
    logic [IQ_DEPTH_LOG-1:0] r_tail;
    logic [IQ_DEPTH_LOG:0]   r_count;

    logic [31:0]         w_seq_pc;
    logic [31:0]         w_next_pc;
    logic                w_pred_taken;
    logic                w_is_jalr;
    logic [BHT_BITS-1:0] w_idx;
    logic [BHT_BITS-1:0] w_upd_idx;
    logic                w_full;
    logic                w_iq_valid;
    logic                w_req;
    logic                w_push;
    logic                w_pop;
    logic                w_unused_upd_bits;

    assign w_seq_pc          = r_pc + 32'd4;
    assign w_idx             = r_pc[BHT_BITS+1:2];
    assign w_upd_idx         = bht_upd_pc[BHT_BITS+1:2];
    assign w_unused_upd_bits = ^{bht_upd_pc[31:BHT_BITS+2], bht_upd_pc[1:0]};
    assign w_full            = (r_count == CNT_FULL);
    assign w_iq_valid        = (r_count != '0);
    assign w_req             = rdy && !rst && !r_wait_jalr && !w_full;
    assign w_push            = w_req && ic_ins_valid && !redirect_valid;
    assign w_pop             = rdy && w_iq_valid && iq_ready && !redirect_valid;

    // Decode the returned instruction into its predicted successor PC
    always_comb begin
        w_next_pc    = w_seq_pc;
        w_pred_taken = 1'b0;
        w_is_jalr    = 1'b0;
        case (ic_ins[6:0])
            OP_JAL: begin
                w_next_pc    = r_pc + j_imm(ic_ins);
                w_pred_taken = 1'b1;
            end
            OP_BRANCH: begin
                if (r_bht[w_idx][1]) begin
                    w_next_pc    = r_pc + b_imm(ic_ins);
                    w_pred_taken = 1'b1;
                end else begin
                    w_next_pc    = w_seq_pc;
                    w_pred_taken = 1'b0;
                end
            end
            OP_JALR: begin
                w_is_jalr = 1'b1;
            end
            default: begin
                w_next_pc = w_seq_pc;
            end
        endcase
    end

    // PC, JALR wait flag, change pulse and queue pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_wait_jalr <= 1'b0;
            r_pc_change <= 1'b0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
        end else if (rdy) begin
            if (redirect_valid) begin
                r_pc        <= redirect_pc;
                r_wait_jalr <= 1'b0;
                r_pc_change <= 1'b1;
                r_head      <= '0;
                r_tail      <= '0;
                r_count     <= '0;
            end else begin
                if (w_push) begin
                    r_pc        <= w_next_pc;
                    r_wait_jalr <= w_is_jalr;
                    r_pc_change <= (w_next_pc != w_seq_pc);
                end else if (jalr_valid && r_wait_jalr) begin
                    r_pc        <= jalr_target;
                    r_wait_jalr <= 1'b0;
                    r_pc_change <= 1'b1;
                end else begin
                    r_pc_change <= 1'b0;
                end
                if (w_push) begin
                    r_tail <= r_tail + PTR_ONE;
                end
                if (w_pop) begin
                    r_head <= r_head + PTR_ONE;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_ONE;
                    2'b01:   r_count <= r_count - CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Predictor training; lookups this cycle still see the old counter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_SIZE; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (rdy && bht_upd_valid) begin
            r_bht[w_upd_idx] <= sat_step(r_bht[w_upd_idx], bht_upd_taken);
        end
    end

    // Queue storage; stale slots are masked by the count on the outputs
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_inst[r_tail]    <= ic_ins;
            r_q_pc[r_tail]      <= r_pc;
            r_q_pred_pc[r_tail] <= w_next_pc;
            r_q_taken[r_tail]   <= w_pred_taken;
        end
    end

    assign ic_addr       = r_pc;
    assign ic_addr_valid = w_req;
    assign ic_pc_change  = r_pc_change;
    assign iq_valid      = w_iq_valid;
    assign iq_inst       = w_iq_valid ? r_q_inst[r_head]    : 32'h0;
    assign iq_pc         = w_iq_valid ? r_q_pc[r_head]      : 32'h0;
    assign iq_pred_pc    = w_iq_valid ? r_q_pred_pc[r_head] : 32'h0;
    assign iq_pred_taken = w_iq_valid ? r_q_taken[r_head]   : 1'b0;

endmodule
